clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Programmable clock divider that generates a 50%-duty divided clock plus single-cycle edge strobes, for driving the I2C test harness (SCL generation) and other slow serial interfaces. It succeeds the fixed divide-by-2 divider. Its half-period length is runtime-loadable and takes effect without glitches, and with the default settings it behaves cycle-for-cycle like the fixed divider. It sits between the system clock domain and the serial interface logic; every output is synchronous to `clk`.

## Interface
Parameters:
- `DIV_W`, 16: width of the divisor and internal counter.
- `DEFAULT_DIV`, 1: half-period length in `clk` cycles loaded at reset. A value of 0 is treated as 1.

Ports:
- `clk` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous reset, active-low.
- `enabled` in 1: count enable. When low, the counter and `clk_out` hold their values.
- `div_val` in DIV_W: new half-period length, sampled when `div_load`=1.
- `div_load` in 1: single-cycle request to load `div_val`.
- `clk_out` out 1: divided clock, registered.
- `rise_tick` out 1: high for the one cycle in which `clk_out` has just become 1.
- `fall_tick` out 1: high for the one cycle in which `clk_out` has just become 0.
- `mid_high_tick`, `mid_low_tick` out 1: present only with `CLK_DIV_QPHASE_EN`. See Configuration.

## Operation
- Registers: `cnt[DIV_W]`, `div_reg[DIV_W]`, `pend_val[DIV_W]`, `pend_flag`.
- Reset (`reset`=0 at a clock edge):
  - `cnt`=0, `clk_out`=0, all ticks=0, `pend_flag`=0.
  - `div_reg`=max(`DEFAULT_DIV`,1).
- Counting (`enabled`=1):
  - If `cnt`==`div_reg`-1 (terminal): `cnt`←0, `clk_out` toggles, and the matching `rise_tick`/`fall_tick` is set for the next cycle.
  - Otherwise `cnt`←`cnt`+1.
- `enabled`=0: `cnt` and `clk_out` hold, ticks are 0, and loads are still captured.
- Divisor load:
  - `div_load`=1 captures `pend_val`←(`div_val`==0 ? 1 : `div_val`) and sets `pend_flag`.
  - A later load before the divisor is applied overwrites the pending value (last wins).
  - The pending value is transferred to `div_reg` only on a terminal edge, and `pend_flag` clears on that edge.
  - If `div_load` coincides with a terminal edge, the new value is applied at that same edge and governs the next half-period.
  - A half-period in progress always completes with the old divisor, so no runt pulses occur.
- Arithmetic: the terminal compare is against `div_reg`-1, with `div_reg` ≥ 1 guaranteed. The counter never exceeds `div_reg`-1 and never wraps past the divisor.
- Reset mid-operation: everything returns to the reset state at that edge, including discarding a pending load.

## Timing
- With `enabled`=1 continuously after reset release, `clk_out` first rises at the D-th enabled edge (D = `div_reg`).
- Output period = 2·D `clk` cycles, with D cycles high and D cycles low.
- D=1 gives a toggle on every enabled edge, identical to the legacy divide-by-2.
- Ticks are registered alongside `clk_out`. There is zero latency between a `clk_out` change and its tick; both are visible in the same cycle.
- Load-to-effect latency is at most D(old) cycles: the divisor applies at the next terminal edge.
- Deasserting `enabled` freezes the phase exactly. On reassertion, counting resumes from the held `cnt`.

## Configuration
- `CLK_DIV_QPHASE_EN` defined:
  - Adds `mid_high_tick` and `mid_low_tick`. Each is high for one cycle while enabled, during the cycle in which `cnt`==`div_reg`>>1 and `div_reg` ≥ 2.
  - `mid_high_tick` fires when `clk_out`=1; `mid_low_tick` fires when `clk_out`=0.
  - Both are registered (computed from next-state) and reset to 0.
  - Purpose: the I2C sample point (mid-high) and data-change point (mid-low).
  - For `div_reg`=1 they never fire.
- `CLK_DIV_QPHASE_EN` not defined: the ports and logic are absent. All other behaviour is unchanged.

## Structure
- Package `clk_div_pkg` holds:
  - the default `DIV_W` constant;
  - the `MIN_DIV`=1 constant;
  - a function that clamps a 0 divisor to 1, shared by the reset and load paths.
- Single module, no sub-module needed. The tick logic is small enough to live inline.

## Test plan
- Legacy equivalence: D=1, `enabled`=1 after reset → `clk_out` toggles on every edge. `rise_tick` is high on odd edges and `fall_tick` on even edges, counted from release.
- D=3: expect `clk_out` 0,0,1,1,1,0,0,0,1 across edges 1–9, giving a period of 6. Exactly one `rise_tick` per period, coincident with `clk_out` 0→1.
- Glitch-free load: D=4. Pulse `div_load` with `div_val`=2 at `cnt`=1 → the current half completes at 4 cycles, then halves are 2 cycles. Loading `div_val`=0 → the divider behaves as D=1.
- Simultaneous load and terminal: load 5 on a terminal edge of D=2 → the very next half-period is 5 cycles. Two loads before a terminal edge (7 then 3) → 3 is applied.
- Enable and reset: deassert `enabled` at `cnt`=2 (D=4) for 10 cycles → `clk_out` and the phase are frozen, then the half resumes with 2 remaining cycles. Assert `reset` mid-half with a load pending → `clk_out`=0, ticks=0, `div_reg`=`DEFAULT_DIV`.
- With `CLK_DIV_QPHASE_EN` and D=4: `mid_high_tick` fires at `cnt`=2 while `clk_out`=1, and `mid_low_tick` at `cnt`=2 while `clk_out`=0. Each fires once per half-period. With D=1 neither fires.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// The divisor clamp is used by both the reset value and the runtime load
// path, so a zero divisor can never reach the terminal compare.
// Supported divisor widths are 1..32 bits (the clamp works on 32 bits).
package clk_div_pkg;

   localparam int DIV_W_DEF = 16;
   localparam int MIN_DIV   = 1;

   // A divisor of zero has no meaningful half-period; treat it as one.
   function automatic logic [31:0] clamp_div(input logic [31:0] v);
      return (v == 32'd0) ? 32'(MIN_DIV) : v;
   endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Programmable 50%-duty clock divider with single-cycle edge strobes.
// The half-period length D is loadable at runtime. A new value is held
// pending and only applied on a terminal edge, so the half-period in
// progress always finishes with the old length (no runt pulses).
// D=1 reproduces the legacy divide-by-2 cycle for cycle.
// Optional build macro CLK_DIV_QPHASE_EN adds mid_high_tick/mid_low_tick,
// marking the middle of the high and low halves (I2C sample and
// data-change points).
module clk_div_prog
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = DIV_W_DEF,
   parameter int DEFAULT_DIV = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enabled,
   input  logic [DIV_W-1:0] div_val,
   input  logic             div_load,
   output logic             clk_out,
   output logic             rise_tick,
   output logic             fall_tick
`ifdef CLK_DIV_QPHASE_EN
   ,
   output logic             mid_high_tick,
   output logic             mid_low_tick
`endif
);

   localparam logic [31:0]      RST_DIV32 = clamp_div(32'(DEFAULT_DIV));
   localparam logic [DIV_W-1:0] RST_DIV   = RST_DIV32[DIV_W-1:0];

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_reg;
   logic [DIV_W-1:0] pend_val;
   logic             pend_flag;

   logic [31:0]      load_val32;
   logic [DIV_W-1:0] load_val;
   logic             terminal;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] div_nxt;
   logic [DIV_W-1:0] pend_val_nxt;
   logic             pend_flag_nxt;
   logic             clk_nxt;
   logic             rise_nxt;
   logic             fall_nxt;
`ifdef CLK_DIV_QPHASE_EN
   logic             mid_pt;
   logic             mid_high_nxt;
   logic             mid_low_nxt;
`endif

   // Next-state of counter, divided clock, divisor hand-over and strobes.
   always_comb begin
      load_val32    = clamp_div(32'(div_val));
      load_val      = load_val32[DIV_W-1:0];
      terminal      = (cnt == (div_reg - DIV_W'(1)));
      cnt_nxt       = cnt;
      clk_nxt       = clk_out;
      div_nxt       = div_reg;
      rise_nxt      = 1'b0;
      fall_nxt      = 1'b0;
      pend_val_nxt  = div_load ? load_val : pend_val;
      pend_flag_nxt = div_load | pend_flag;
      if (enabled) begin
         if (terminal) begin
            cnt_nxt       = '0;
            clk_nxt       = ~clk_out;
            rise_nxt      = ~clk_out;
            fall_nxt      = clk_out;
            pend_flag_nxt = 1'b0;
            // A load arriving on the terminal edge itself wins over an
            // older pending value and governs the very next half-period.
            if (div_load)
               div_nxt = load_val;
            else if (pend_flag)
               div_nxt = pend_val;
         end else begin
            cnt_nxt = cnt + DIV_W'(1);
         end
      end
`ifdef CLK_DIV_QPHASE_EN
      // Evaluated on next-state so the registered strobe lines up with
      // the cycle in which cnt sits at the half-way point.
      mid_pt       = enabled && (div_nxt >= DIV_W'(2)) && (cnt_nxt == (div_nxt >> 1));
      mid_high_nxt = mid_pt & clk_nxt;
      mid_low_nxt  = mid_pt & ~clk_nxt;
`endif
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt       <= '0;
         div_reg   <= RST_DIV;
         pend_val  <= RST_DIV;
         pend_flag <= 1'b0;
         clk_out   <= 1'b0;
         rise_tick <= 1'b0;
         fall_tick <= 1'b0;
`ifdef CLK_DIV_QPHASE_EN
         mid_high_tick <= 1'b0;
         mid_low_tick  <= 1'b0;
`endif
      end else begin
         cnt       <= cnt_nxt;
         div_reg   <= div_nxt;
         pend_val  <= pend_val_nxt;
         pend_flag <= pend_flag_nxt;
         clk_out   <= clk_nxt;
         rise_tick <= rise_nxt;
         fall_tick <= fall_nxt;
`ifdef CLK_DIV_QPHASE_EN
         mid_high_tick <= mid_high_nxt;
         mid_low_tick  <= mid_low_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed self-checking bench for clk_div_prog. A second instance with
// DEFAULT_DIV=3 checks the reset-loaded divisor from release.
// Build with CLK_DIV_QPHASE_EN defined to also exercise the mid-phase ticks.
module tb_clk_div_prog;

   logic        clk = 1'b0;
   logic        reset;
   logic        enabled;
   logic [15:0] div_val;
   logic        div_load;
   logic        clk_out, rise_tick, fall_tick;

   logic [15:0] div_val3  = 16'd0;
   logic        div_load3 = 1'b0;
   logic        clk_out3, rise3, fall3;

`ifdef CLK_DIV_QPHASE_EN
   logic mid_high_tick, mid_low_tick;
   logic mid_high3, mid_low3;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   clk_div_prog #(.DIV_W(16), .DEFAULT_DIV(1)) dut (
      .clk(clk), .reset(reset), .enabled(enabled), .div_val(div_val),
      .div_load(div_load), .clk_out(clk_out), .rise_tick(rise_tick),
      .fall_tick(fall_tick)
`ifdef CLK_DIV_QPHASE_EN
      , .mid_high_tick(mid_high_tick), .mid_low_tick(mid_low_tick)
`endif
   );

   clk_div_prog #(.DIV_W(16), .DEFAULT_DIV(3)) dut3 (
      .clk(clk), .reset(reset), .enabled(enabled), .div_val(div_val3),
      .div_load(div_load3), .clk_out(clk_out3), .rise_tick(rise3),
      .fall_tick(fall3)
`ifdef CLK_DIV_QPHASE_EN
      , .mid_high_tick(mid_high3), .mid_low_tick(mid_low3)
`endif
   );

   // Advance one edge; outputs are stable 1 time unit afterwards.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Two reset edges, then release so the next edge is edge 1.
   task automatic do_reset();
      reset    = 1'b0;
      enabled  = 1'b0;
      div_load = 1'b0;
      div_val  = 16'd0;
      step();
      step();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      enabled  = 1'b1;
      div_load = 1'b0;
      div_val  = 16'd0;
      step();
      step();
      n_checks++;
      if ({clk_out, rise_tick, fall_tick} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b want 000", {clk_out, rise_tick, fall_tick});
      end
      n_checks++;
      if ({clk_out3, rise3, fall3} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs_d3: got %b want 000", {clk_out3, rise3, fall3});
      end
      reset = 1'b1;
   endtask

   task automatic test_legacy();
      int e3 [0:12];
      int ec, pc;
      e3 = '{0, 0,0,1,1,1,0,0,0,1,1,1,0};
      do_reset();
      enabled = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         step();
         ec = i % 2;
         n_checks++;
         if ({clk_out, rise_tick, fall_tick} !== {ec[0], ec[0], ~ec[0]}) begin
            n_fail++;
            $display("FAIL legacy_d1 edge %0d: got clk/rise/fall %b want %b", i,
                     {clk_out, rise_tick, fall_tick}, {ec[0], ec[0], ~ec[0]});
         end
         pc = e3[i-1];
         ec = e3[i];
         n_checks++;
         if ({clk_out3, rise3, fall3} !== {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]}) begin
            n_fail++;
            $display("FAIL default_d3 edge %0d: got clk/rise/fall %b want %b", i,
                     {clk_out3, rise3, fall3}, {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]});
         end
      end
   endtask

   task automatic test_glitch_free();
      int ex [0:20];
      int ec, pc;
      ex = '{0, 1,1,1,1,0,0,0,0,1,1,0,0,1,1,0,1,0,1,0,1};
      do_reset();
      enabled = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         div_load = (i == 1) || (i == 7) || (i == 15);
         div_val  = (i == 1) ? 16'd4 : (i == 7) ? 16'd2 : 16'd0;
         step();
         div_load = 1'b0;
         pc = ex[i-1];
         ec = ex[i];
         n_checks++;
         if ({clk_out, rise_tick, fall_tick} !== {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]}) begin
            n_fail++;
            $display("FAIL glitch_free_load edge %0d: got clk/rise/fall %b want %b", i,
                     {clk_out, rise_tick, fall_tick}, {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]});
         end
      end
   endtask

   task automatic test_simul_load();
      int ex [0:21];
      int ec, pc;
      ex = '{0, 1,1,0,0,1,1,1,1,1,0,0,0,0,0,1,1,1,0,0,0,1};
      do_reset();
      enabled = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         div_load = (i == 1) || (i == 5) || (i == 11) || (i == 12);
         div_val  = (i == 1) ? 16'd2 : (i == 5) ? 16'd5 : (i == 11) ? 16'd7 : 16'd3;
         step();
         div_load = 1'b0;
         pc = ex[i-1];
         ec = ex[i];
         n_checks++;
         if ({clk_out, rise_tick, fall_tick} !== {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]}) begin
            n_fail++;
            $display("FAIL simul_load edge %0d: got clk/rise/fall %b want %b", i,
                     {clk_out, rise_tick, fall_tick}, {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]});
         end
      end
   endtask

   task automatic test_enable_freeze();
      int ex [0:19];
      int ec, pc;
      ex = '{0, 1,1,1,1,1,1,1,1,1,1,1,1,1,1,0,0,1,1,0};
      do_reset();
      for (int i = 1; i <= 19; i++) begin
         enabled  = !((i >= 4) && (i <= 13));
         div_load = (i == 1) || (i == 8);
         div_val  = (i == 1) ? 16'd4 : 16'd2;
         step();
         div_load = 1'b0;
         pc = ex[i-1];
         ec = ex[i];
         n_checks++;
         if ({clk_out, rise_tick, fall_tick} !== {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]}) begin
            n_fail++;
            $display("FAIL enable_freeze edge %0d: got clk/rise/fall %b want %b", i,
                     {clk_out, rise_tick, fall_tick}, {ec[0], ec[0] & ~pc[0], pc[0] & ~ec[0]});
         end
      end
      enabled = 1'b1;
   endtask

   task automatic test_reset_mid();
      int ec;
      do_reset();
      enabled  = 1'b1;
      div_load = 1'b1;
      div_val  = 16'd3;
      step();
      div_val  = 16'd6;
      step();
      div_load = 1'b0;
      reset    = 1'b0;
      step();
      n_checks++;
      if ({clk_out, rise_tick, fall_tick} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_mid_half: got clk/rise/fall %b want 000", {clk_out, rise_tick, fall_tick});
      end
      step();
      reset = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         step();
         ec = i % 2;
         n_checks++;
         if ({clk_out, rise_tick, fall_tick} !== {ec[0], ec[0], ~ec[0]}) begin
            n_fail++;
            $display("FAIL reset_mid_default_div edge %0d: got clk/rise/fall %b want %b", i,
                     {clk_out, rise_tick, fall_tick}, {ec[0], ec[0], ~ec[0]});
         end
      end
      reset = 1'b0;
      step();
      n_checks++;
      if ({clk_out, rise_tick, fall_tick} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_clears_ticks: got clk/rise/fall %b want 000", {clk_out, rise_tick, fall_tick});
      end
      reset = 1'b1;
   endtask

`ifdef CLK_DIV_QPHASE_EN
   task automatic test_qphase();
      logic eh, el;
      do_reset();
      enabled = 1'b1;
      for (int i = 1; i <= 18; i++) begin
         div_load = (i == 1) || (i == 13);
         div_val  = (i == 1) ? 16'd4 : 16'd1;
         step();
         div_load = 1'b0;
         eh = (i == 3) || (i == 11);
         el = (i == 7);
         n_checks++;
         if ({mid_high_tick, mid_low_tick} !== {eh, el}) begin
            n_fail++;
            $display("FAIL qphase edge %0d: got high/low %b want %b", i,
                     {mid_high_tick, mid_low_tick}, {eh, el});
         end
      end
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      enabled  = 1'b0;
      div_load = 1'b0;
      div_val  = 16'd0;
      test_reset();
      test_legacy();
      test_glitch_free();
      test_simul_load();
      test_enable_freeze();
      test_reset_mid();
`ifdef CLK_DIV_QPHASE_EN
      test_qphase();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
